lock_queue_manager: RTL and testbench
=====================================

# lock_queue_manager

Queued lock manager serving up to 16 accelerators over the lock command stream. It replaces the immediate-NACK behaviour of the basic Lock for blocking requests with a per-lock waiter set. A blocking lock on a held lock is parked rather than rejected. On unlock, ownership passes directly to the next waiter in round-robin order, and that waiter receives its grant ack then. It sits between the accelerator command interconnect (inStream, TID = requester) and the ack return path (outStream, TDEST = requester).

## Interface
- NUM_LOCKS, 4: number of lock IDs managed (1..16); stored state per lock: locked bit, 4-bit owner, 16-bit waiter mask.
- clk  in  1  clock; all state on rising edge.
- rstn  in  1  asynchronous active-low reset.
- inStream_TDATA  in  64  command; [7:0] opcode, [15:8] lock_id, [63:16] ignored.
- inStream_TVALID  in  1  command valid.
- inStream_TID  in  4  requester ID.
- inStream_TREADY  out  1  command accepted when TVALID & TREADY at rising edge.
- outStream_TDATA  out  8  ack: 0x01 granted, 0x00 busy.
- outStream_TVALID  out  1  ack valid; held until accepted.
- outStream_TREADY  in  1  ack consumer ready.
- outStream_TDEST  out  4  destination requester of ack.

## Operation
- Opcodes: 0x04 LOCK (blocking), 0x05 TRYLOCK (non-blocking), 0x06 UNLOCK; any other opcode dropped, no ack.
- lock_id >= NUM_LOCKS: command dropped, no ack, no state change.
- States: IDLE → EXEC → (ACK | IDLE); ACK → IDLE on output handshake.
- IDLE: TREADY=1; on accept, register opcode, lock_id, TID; go EXEC.
- EXEC (TREADY=0), one cycle, for the addressed lock:
  - LOCK, free: locked=1, owner=TID; ack 0x01 to TID.
  - LOCK, owned by TID: no state change; ack 0x01 to TID.
  - LOCK, owned by other: set waiters[TID]; no ack; go IDLE.
  - LOCK, TID already waiting: no change, no ack.
  - TRYLOCK, free: same as LOCK free. TRYLOCK, owned by TID: ack 0x01. TRYLOCK, owned by other: ack 0x00, waiters unchanged.
  - UNLOCK by owner, waiters==0: locked=0; no ack.
  - UNLOCK by owner, waiters!=0: next owner = first set waiter bit scanning upward from (old owner+1) mod 16 with wrap. Clear its waiter bit, set owner; lock stays locked; ack 0x01 to new owner.
  - UNLOCK by non-owner or on free lock: ignored, no ack.
- ACK: outStream_TVALID=1, TDATA/TDEST stable until TVALID & TREADY; TREADY=0 throughout.
- At most one command in flight; no outstanding-ack queue needed.

## Timing
- Reset (async, immediate): state IDLE, all locked/owner/waiters cleared, outStream_TVALID=0, outStream_TDATA=0, outStream_TDEST=0, inStream_TREADY=0.
- First rising edge after rstn release: inStream_TREADY=1.
- Command accepted at edge N: TREADY=0 from N. EXEC at edge N+1. If an ack is produced, outStream_TVALID=1 with valid TDATA/TDEST after edge N+2.
- No-ack command accepted at edge N: TREADY=1 again after edge N+1.
- Ack accepted at edge M: TVALID=0 and TREADY=1 after edge M.
- outStream_TREADY high before TVALID: handshake completes at first edge with TVALID=1.
- Reset mid-ACK or mid-EXEC: the pending ack is discarded and all lock ownership is lost.

## Test plan
- Reset, then LOCK id0 from TID 0 (TDATA 0x04) → after 2 edges TVALID=1, TDEST=0, TDATA=0x01; TREADY pulse → TVALID=0, TREADY=1.
- TRYLOCK id0 from TID 1 (0x05) while held by 0 → TDEST=1, TDATA=0x00; no waiter recorded. Later UNLOCK by 0 (0x06) → no ack, lock free.
- LOCK id0 by TID 0, then LOCK id0 by TIDs 3 and 9 → no acks to 3 or 9. UNLOCK by 0 → ack 0x01 to TDEST=3. UNLOCK by 3 → ack to 9. UNLOCK by 9 → no ack, free.
- Wrap-around: owner 14; waiters 2 and 15; UNLOCK by 14 → grant 15. UNLOCK by 15 → grant 2 (wrap).
- Ack with outStream_TREADY held low 10 cycles → TVALID, TDATA, TDEST stable and inStream_TREADY=0 the whole time.
- Edge cases:
  - lock_id 0x05 with NUM_LOCKS=4 → dropped.
  - Opcode 0x07 → dropped.
  - UNLOCK id1 (0x0106) by non-owner → ignored.
  - All three: no ack, TREADY=1 after one edge.
  - Reset asserted during ACK → TVALID=0 immediately; subsequent LOCK id0 grants.

Source files
------------

// File: rtl/lock_queue_manager.sv
// lock_queue_manager: queued lock manager; blocking LOCKs on held locks park in a per-lock waiter set
// and UNLOCK hands ownership to the next waiter in round-robin order.
module lock_queue_manager #(
    parameter int NUM_LOCKS = 4
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic [63:0] inStream_TDATA,
    input  logic        inStream_TVALID,
    input  logic [3:0]  inStream_TID,
    output logic        inStream_TREADY,
    output logic [7:0]  outStream_TDATA,
    output logic        outStream_TVALID,
    input  logic        outStream_TREADY,
    output logic [3:0]  outStream_TDEST
);
    localparam logic [7:0] OP_LOCK = 8'h04, OP_TRY = 8'h05, OP_UNLOCK = 8'h06;
    typedef enum logic [1:0] {IDLE, EXEC, ACK} state_t;
    state_t state_q, state_d;
    logic [7:0] op_q, op_d, id_q, id_d, out_data_q, out_data_d;
    logic [3:0] tid_q, tid_d, out_dest_q, out_dest_d;
    logic out_valid_q, out_valid_d, in_ready_q, in_ready_d;
    logic [NUM_LOCKS-1:0] locked_q, locked_d;
    logic [NUM_LOCKS-1:0][3:0] owner_q, owner_d;
    logic [NUM_LOCKS-1:0][15:0] waiters_q, waiters_d;
    logic hit, sel_locked, n_locked, found, is_owner, ack;
    logic [3:0] sel_owner, n_owner, nxt, cand, ack_dest;
    logic [15:0] sel_wait, n_wait;
    logic [7:0] ack_data;
    logic unused_bits;
    assign unused_bits = ^inStream_TDATA[63:16];
    assign inStream_TREADY = in_ready_q;
    assign outStream_TVALID = out_valid_q;
    assign outStream_TDATA = out_data_q;
    assign outStream_TDEST = out_dest_q;
    always_comb begin
        state_d = state_q;
        op_d = op_q;
        id_d = id_q;
        tid_d = tid_q;
        out_data_d = out_data_q;
        out_dest_d = out_dest_q;
        out_valid_d = out_valid_q;
        locked_d = locked_q;
        owner_d = owner_q;
        waiters_d = waiters_q;
        hit = 1'b0;
        sel_locked = 1'b0;
        sel_owner = '0;
        sel_wait = '0;
        for (int l = 0; l < NUM_LOCKS; l++) begin
            if (id_q == 8'(l)) begin
                hit = 1'b1;
                sel_locked = locked_q[l];
                sel_owner = owner_q[l];
                sel_wait = waiters_q[l];
            end
        end
        // Round-robin: first waiter strictly after the current owner, wrapping at 16
        found = 1'b0;
        nxt = sel_owner;
        cand = '0;
        for (int k = 1; k <= 16; k++) begin
            cand = sel_owner + 4'(k);
            if (!found && sel_wait[cand]) begin
                found = 1'b1;
                nxt = cand;
            end
        end
        is_owner = sel_locked && sel_owner == tid_q;
        n_locked = sel_locked;
        n_owner = sel_owner;
        n_wait = sel_wait;
        ack = 1'b0;
        ack_data = 8'h00;
        ack_dest = tid_q;
        if (op_q == OP_LOCK || op_q == OP_TRY) begin
            if (!sel_locked) begin
                n_locked = 1'b1;
                n_owner = tid_q;
                ack = 1'b1;
                ack_data = 8'h01;
            end else if (is_owner) begin
                ack = 1'b1;
                ack_data = 8'h01;
            end else if (op_q == OP_LOCK) begin
                n_wait[tid_q] = 1'b1;
            end else begin
                ack = 1'b1;
            end
        end else if (op_q == OP_UNLOCK && is_owner) begin
            if (!found) begin
                n_locked = 1'b0;
            end else begin
                n_owner = nxt;
                n_wait[nxt] = 1'b0;
                ack = 1'b1;
                ack_data = 8'h01;
                ack_dest = nxt;
            end
        end
        case (state_q)
            IDLE: begin
                if (inStream_TVALID && in_ready_q) begin
                    op_d = inStream_TDATA[7:0];
                    id_d = inStream_TDATA[15:8];
                    tid_d = inStream_TID;
                    state_d = EXEC;
                end
            end
            EXEC: begin
                state_d = (hit && ack) ? ACK : IDLE;
                for (int l = 0; l < NUM_LOCKS; l++) begin
                    if (id_q == 8'(l)) begin
                        locked_d[l] = n_locked;
                        owner_d[l] = n_owner;
                        waiters_d[l] = n_wait;
                    end
                end
                if (hit && ack) begin
                    out_data_d = ack_data;
                    out_dest_d = ack_dest;
                end
            end
            ACK: begin
                out_valid_d = 1'b1;
                if (out_valid_q && outStream_TREADY) begin
                    out_valid_d = 1'b0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        in_ready_d = state_d == IDLE;
    end
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= IDLE;
            op_q <= '0;
            id_q <= '0;
            tid_q <= '0;
            out_data_q <= '0;
            out_dest_q <= '0;
            out_valid_q <= 1'b0;
            in_ready_q <= 1'b0;
            locked_q <= '0;
            owner_q <= '0;
            waiters_q <= '0;
        end else begin
            state_q <= state_d;
            op_q <= op_d;
            id_q <= id_d;
            tid_q <= tid_d;
            out_data_q <= out_data_d;
            out_dest_q <= out_dest_d;
            out_valid_q <= out_valid_d;
            in_ready_q <= in_ready_d;
            locked_q <= locked_d;
            owner_q <= owner_d;
            waiters_q <= waiters_d;
        end
    end
endmodule

// File: tb/tb_lock_queue_manager.sv
// tb_lock_queue_manager: directed command vectors with hand-computed acks, plus stall and reset sequences.
module tb_lock_queue_manager;
    logic clk = 1'b0, rstn = 1'b0;
    logic [63:0] in_data = '0;
    logic in_valid = 1'b0, out_ready = 1'b0;
    logic [3:0] in_tid = '0;
    logic in_ready, out_valid;
    logic [7:0] out_data;
    logic [3:0] out_dest;
    int total = 0, bad = 0;
    lock_queue_manager #(.NUM_LOCKS(4)) dut (
        .clk(clk), .rstn(rstn),
        .inStream_TDATA(in_data), .inStream_TVALID(in_valid), .inStream_TID(in_tid),
        .inStream_TREADY(in_ready),
        .outStream_TDATA(out_data), .outStream_TVALID(out_valid),
        .outStream_TREADY(out_ready), .outStream_TDEST(out_dest)
    );
    always #5 clk = ~clk;
    typedef struct {
        logic [7:0] op;
        logic [7:0] id;
        logic [3:0] tid;
        bit         ack;
        logic [7:0] dat;
        logic [3:0] dst;
    } vec_t;
    vec_t vecs[32];
    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, got, exp, $time);
        end
    endtask
    task automatic do_cmd(input logic [7:0] op, input logic [7:0] id, input logic [3:0] tid,
                          input bit ack, input logic [7:0] dat, input logic [3:0] dst,
                          input int stall, input bit early);
        int n = 0;
        @(negedge clk);
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("ready_wait", in_ready, 1);
        in_data = {48'h0, id, op};
        in_tid = tid;
        in_valid = 1'b1;
        out_ready = early;
        @(posedge clk);
        #1 in_valid = 1'b0;
        chk("busy_after_accept", in_ready, 0);
        @(posedge clk);
        #1;
        if (!ack) begin
            chk("noack_valid", out_valid, 0);
            chk("noack_ready", in_ready, 1);
        end else begin
            chk("exec_valid", out_valid, 0);
            chk("exec_ready", in_ready, 0);
            @(posedge clk);
            #1;
            chk("ack_valid", out_valid, 1);
            chk("ack_data", out_data, dat);
            chk("ack_dest", out_dest, dst);
            for (int s = 0; s < stall; s++) begin
                @(posedge clk);
                #1;
                chk("stall_valid", out_valid, 1);
                chk("stall_data", out_data, dat);
                chk("stall_dest", out_dest, dst);
                chk("stall_inready", in_ready, 0);
            end
            out_ready = 1'b1;
            @(posedge clk);
            #1;
            chk("post_ack_valid", out_valid, 0);
            chk("post_ack_ready", in_ready, 1);
        end
        out_ready = 1'b0;
    endtask
    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end
    initial begin
        vecs[0]  = '{8'h04, 8'd0, 4'd0,  1, 8'h01, 4'd0};
        vecs[1]  = '{8'h05, 8'd0, 4'd1,  1, 8'h00, 4'd1};
        vecs[2]  = '{8'h06, 8'd0, 4'd0,  0, 8'h00, 4'd0};
        vecs[3]  = '{8'h05, 8'd0, 4'd1,  1, 8'h01, 4'd1};
        vecs[4]  = '{8'h06, 8'd0, 4'd1,  0, 8'h00, 4'd0};
        vecs[5]  = '{8'h04, 8'd0, 4'd0,  1, 8'h01, 4'd0};
        vecs[6]  = '{8'h04, 8'd0, 4'd3,  0, 8'h00, 4'd0};
        vecs[7]  = '{8'h04, 8'd0, 4'd9,  0, 8'h00, 4'd0};
        vecs[8]  = '{8'h04, 8'd0, 4'd3,  0, 8'h00, 4'd0};
        vecs[9]  = '{8'h06, 8'd0, 4'd0,  1, 8'h01, 4'd3};
        vecs[10] = '{8'h06, 8'd0, 4'd3,  1, 8'h01, 4'd9};
        vecs[11] = '{8'h06, 8'd0, 4'd9,  0, 8'h00, 4'd0};
        vecs[12] = '{8'h05, 8'd0, 4'd5,  1, 8'h01, 4'd5};
        vecs[13] = '{8'h06, 8'd0, 4'd5,  0, 8'h00, 4'd0};
        vecs[14] = '{8'h04, 8'd2, 4'd14, 1, 8'h01, 4'd14};
        vecs[15] = '{8'h04, 8'd2, 4'd2,  0, 8'h00, 4'd0};
        vecs[16] = '{8'h04, 8'd2, 4'd15, 0, 8'h00, 4'd0};
        vecs[17] = '{8'h06, 8'd2, 4'd14, 1, 8'h01, 4'd15};
        vecs[18] = '{8'h06, 8'd2, 4'd15, 1, 8'h01, 4'd2};
        vecs[19] = '{8'h06, 8'd2, 4'd2,  0, 8'h00, 4'd0};
        vecs[20] = '{8'h04, 8'd5, 4'd0,  0, 8'h00, 4'd0};
        vecs[21] = '{8'h07, 8'd0, 4'd0,  0, 8'h00, 4'd0};
        vecs[22] = '{8'h04, 8'd1, 4'd4,  1, 8'h01, 4'd4};
        vecs[23] = '{8'h06, 8'd1, 4'd6,  0, 8'h00, 4'd0};
        vecs[24] = '{8'h05, 8'd1, 4'd6,  1, 8'h00, 4'd6};
        vecs[25] = '{8'h04, 8'd0, 4'd7,  1, 8'h01, 4'd7};
        vecs[26] = '{8'h04, 8'd1, 4'd4,  1, 8'h01, 4'd4};
        vecs[27] = '{8'h04, 8'd3, 4'd1,  1, 8'h01, 4'd1};
        vecs[28] = '{8'h04, 8'd3, 4'd0,  0, 8'h00, 4'd0};
        vecs[29] = '{8'h04, 8'd3, 4'd5,  0, 8'h00, 4'd0};
        vecs[30] = '{8'h06, 8'd3, 4'd1,  1, 8'h01, 4'd5};
        vecs[31] = '{8'h06, 8'd3, 4'd5,  1, 8'h01, 4'd0};
        #12;
        chk("reset_valid", out_valid, 0);
        chk("reset_ready", in_ready, 0);
        chk("reset_data", out_data, 0);
        chk("reset_dest", out_dest, 0);
        @(negedge clk);
        rstn = 1'b1;
        @(posedge clk);
        #1 chk("first_edge_ready", in_ready, 1);
        for (int i = 0; i < 32; i++)
            do_cmd(vecs[i].op, vecs[i].id, vecs[i].tid, vecs[i].ack, vecs[i].dat, vecs[i].dst, 0, 0);
        do_cmd(8'h05, 8'd1, 4'd8, 1, 8'h00, 4'd8, 10, 0);
        do_cmd(8'h05, 8'd1, 4'd4, 1, 8'h01, 4'd4, 0, 1);
        @(negedge clk);
        in_data = {48'h0, 8'd0, 8'h05};
        in_tid = 4'd2;
        in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1 chk("pre_reset_valid", out_valid, 1);
        rstn = 1'b0;
        #1;
        chk("async_reset_valid", out_valid, 0);
        chk("async_reset_ready", in_ready, 0);
        chk("async_reset_data", out_data, 0);
        chk("async_reset_dest", out_dest, 0);
        @(negedge clk);
        rstn = 1'b1;
        @(posedge clk);
        #1 chk("rerelease_ready", in_ready, 1);
        do_cmd(8'h04, 8'd0, 4'd2, 1, 8'h01, 4'd2, 0, 0);
        do_cmd(8'h04, 8'd1, 4'd6, 1, 8'h01, 4'd6, 0, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
